rx_ipv4_seq: RTL

Receive-side IPv4 sequencer between the MAC's IPv4 payload stream and the UDP receiver. It counts header bytes including options and bounds the payload by Total Length, stripping Ethernet padding. It filters on destination IP, fragmentation and (optionally) header checksum, then emits a qualified, framed payload stream with accept/drop status.

---
 rtl/rx_ipv4_pkg.sv | 46 ++++
 rtl/ipv4_csum_acc.sv | 51 +++++
 rtl/rx_ipv4_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rx_ipv4_pkg.sv
// Shared types and constants for the receive-side IPv4 sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rx_ipv4_pkg;

  localparam int         OCT = 8;
  localparam logic [7:0] UDP = 8'h11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_DISCARD
  } state_t;

  // Drop reasons; a lower code wins when several apply.
  localparam logic [2:0] DROP_NONE        = 3'd0;
  localparam logic [2:0] DROP_BAD_VER_IHL = 3'd1;
  localparam logic [2:0] DROP_BAD_LEN     = 3'd2;
  localparam logic [2:0] DROP_BAD_CSUM    = 3'd3;
  localparam logic [2:0] DROP_NOT_MINE    = 3'd4;
  localparam logic [2:0] DROP_FRAG        = 3'd5;
  localparam logic [2:0] DROP_HDR_TRUNC   = 3'd6;

  // Byte offsets within the IPv4 header.
  localparam logic [7:0] OFF_TLEN_HI = 8'd2;
  localparam logic [7:0] OFF_TLEN_LO = 8'd3;
  localparam logic [7:0] OFF_FRAG_HI = 8'd6;
  localparam logic [7:0] OFF_FRAG_LO = 8'd7;
  localparam logic [7:0] OFF_PROTO   = 8'd9;
  localparam logic [7:0] OFF_SRC0    = 8'd12;
  localparam logic [7:0] OFF_SRC3    = 8'd15;
  localparam logic [7:0] OFF_DST0    = 8'd16;
  localparam logic [7:0] OFF_DST3    = 8'd19;

  localparam logic [31:0] BCAST_IP = 32'hFFFF_FFFF;

  // One's-complement 16-bit add with end-around carry; a single fold is
  // enough because two 16-bit operands cannot carry twice.
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ipv4_csum_acc.sv
// Running one's-complement sum of header bytes (built only with RX_IPV4_CSUM_EN).
// Latency: sum registered 1 cycle; ok_next is combinational and includes byte_in.
// Backpressure: none; consumes a byte whenever byte_vld is high.
`ifdef RX_IPV4_CSUM_EN
module ipv4_csum_acc
  import rx_ipv4_pkg::*;
(
  input  logic           RX_CLK,
  input  logic           rst,
  input  logic           clr,
  input  logic           byte_vld,
  input  logic [OCT-1:0] byte_in,
  output logic [15:0]    sum,
  output logic           ok_next
);

  logic [7:0]  hi_byte;
  logic        odd;
  logic [15:0] base_sum;
  logic        base_odd;
  logic [15:0] sum_next;

  // clr restarts the sum; a byte arriving with clr is the first byte of the new sum.
  assign base_sum = clr ? 16'd0 : sum;
  assign base_odd = clr ? 1'b0  : odd;
  assign sum_next = csum_add(base_sum, {hi_byte, byte_in});
  assign ok_next  = byte_vld && base_odd && (sum_next == 16'hFFFF);

  // Even bytes are parked as the high half; odd bytes complete a word and add it in.
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      sum     <= 16'd0;
      hi_byte <= 8'd0;
      odd     <= 1'b0;
    end else if (byte_vld) begin
      if (base_odd) begin
        sum <= sum_next;
        odd <= 1'b0;
      end else begin
        sum     <= base_sum;
        hi_byte <= byte_in;
        odd     <= 1'b1;
      end
    end else if (clr) begin
      sum <= 16'd0;
      odd <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/rx_ipv4_seq.sv
// IPv4 receive sequencer: parses/filters the header, forwards the payload bounded by Total Length. Checksum check enabled by RX_IPV4_CSUM_EN.
// Latency: payload 1 cycle registered; accept/drop the cycle after the last header byte; trunc the cycle after valid falls.
// Backpressure: none; the input stream cannot be stalled, trailing pad bytes are absorbed in DISCARD.
module rx_ipv4_seq
  import rx_ipv4_pkg::*;
(
  input  logic           RX_CLK,
  input  logic           rst,
  input  logic [31:0]    ip_addr,
  input  logic           rx_payload_ipv4,
  input  logic [OCT-1:0] rx_payload,
  output logic [31:0]    rx_src_ip,
  output logic [7:0]     rx_proto,
  output logic           rx_is_udp,
  output logic           rx_data_valid,
  output logic [OCT-1:0] rx_data,
  output logic           rx_data_sop,
  output logic           rx_data_eop,
  output logic           rx_accept,
  output logic           rx_drop,
  output logic [2:0]     rx_drop_code,
  output logic           rx_trunc
);

  state_t      state;
  logic [7:0]  hcnt;
  logic [3:0]  ihl;
  logic [15:0] tot_len;
  logic [13:0] frag;
  logic [7:0]  proto;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic [15:0] remain;
  logic        sop_pend;

  logic [7:0]  hdr_len;
  logic        hdr_last;
  logic [31:0] dst_cmp;
  logic [15:0] payload_len;
  logic [2:0]  dec_code;
  logic        csum_ok;

  assign hdr_len     = {2'b00, ihl, 2'b00};
  assign hdr_last    = (hcnt == hdr_len - 8'd1);
  // With IHL=5 the decision byte is the last destination byte itself.
  assign dst_cmp     = (hcnt == OFF_DST3) ? {dst_ip[23:0], rx_payload} : dst_ip;
  assign payload_len = tot_len - {8'd0, hdr_len};

`ifdef RX_IPV4_CSUM_EN
  logic [15:0] csum_sum;
  ipv4_csum_acc u_csum (
    .RX_CLK   (RX_CLK),
    .rst      (rst),
    .clr      (state == ST_IDLE),
    .byte_vld (rx_payload_ipv4 && (state == ST_IDLE || state == ST_HDR)),
    .byte_in  (rx_payload),
    .sum      (csum_sum),
    .ok_next  (csum_ok)
  );
`else
  assign csum_ok = 1'b1;
`endif

  // Header verdict for the last header byte; lowest applicable code wins.
  always_comb begin
    dec_code = DROP_NONE;
    if (tot_len < {8'd0, hdr_len})
      dec_code = DROP_BAD_LEN;
    else if (!csum_ok)
      dec_code = DROP_BAD_CSUM;
    else if (dst_cmp != ip_addr && dst_cmp != BCAST_IP)
      dec_code = DROP_NOT_MINE;
    else if (frag[13] || frag[12:0] != 13'd0)
      dec_code = DROP_FRAG;
  end

  // Frame sequencer: header capture, verdict, payload forwarding and status pulses.
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      hcnt          <= 8'd0;
      ihl           <= 4'd0;
      tot_len       <= 16'd0;
      frag          <= 14'd0;
      proto         <= 8'd0;
      src_ip        <= 32'd0;
      dst_ip        <= 32'd0;
      remain        <= 16'd0;
      sop_pend      <= 1'b0;
      rx_src_ip     <= 32'd0;
      rx_proto      <= 8'd0;
      rx_is_udp     <= 1'b0;
      rx_data_valid <= 1'b0;
      rx_data       <= '0;
      rx_data_sop   <= 1'b0;
      rx_data_eop   <= 1'b0;
      rx_accept     <= 1'b0;
      rx_drop       <= 1'b0;
      rx_drop_code  <= 3'd0;
      rx_trunc      <= 1'b0;
    end else begin
      rx_accept     <= 1'b0;
      rx_drop       <= 1'b0;
      rx_trunc      <= 1'b0;
      rx_data_valid <= 1'b0;
      rx_data_sop   <= 1'b0;
      rx_data_eop   <= 1'b0;
      if (!rx_payload_ipv4) begin
        if (state == ST_HDR) begin
          rx_drop      <= 1'b1;
          rx_drop_code <= DROP_HDR_TRUNC;
        end
        if (state == ST_PAYLOAD && remain != 16'd0)
          rx_trunc <= 1'b1;
        state    <= ST_IDLE;
        hcnt     <= 8'd0;
        remain   <= 16'd0;
        sop_pend <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            ihl  <= rx_payload[3:0];
            hcnt <= 8'd1;
            if (rx_payload[7:4] != 4'd4 || rx_payload[3:0] < 4'd5) begin
              rx_drop      <= 1'b1;
              rx_drop_code <= DROP_BAD_VER_IHL;
              state        <= ST_DISCARD;
            end else begin
              state <= ST_HDR;
            end
          end
          ST_HDR: begin
            hcnt <= hcnt + 8'd1;
            case (hcnt)
              OFF_TLEN_HI: tot_len[15:8] <= rx_payload;
              OFF_TLEN_LO: tot_len[7:0]  <= rx_payload;
              OFF_FRAG_HI: frag[13:8]    <= rx_payload[5:0];
              OFF_FRAG_LO: frag[7:0]     <= rx_payload;
              OFF_PROTO:   proto         <= rx_payload;
              default: ;
            endcase
            if (hcnt >= OFF_SRC0 && hcnt <= OFF_SRC3)
              src_ip <= {src_ip[23:0], rx_payload};
            if (hcnt >= OFF_DST0 && hcnt <= OFF_DST3)
              dst_ip <= {dst_ip[23:0], rx_payload};
            if (hdr_last) begin
              if (dec_code != DROP_NONE) begin
                rx_drop      <= 1'b1;
                rx_drop_code <= dec_code;
                state        <= ST_DISCARD;
              end else begin
                rx_accept <= 1'b1;
                rx_src_ip <= src_ip;
                rx_proto  <= proto;
                rx_is_udp <= (proto == UDP);
                remain    <= payload_len;
                sop_pend  <= 1'b1;
                // A zero-length payload just waits out the frame silently.
                state     <= (payload_len != 16'd0) ? ST_PAYLOAD : ST_DISCARD;
              end
            end
          end
          ST_PAYLOAD: begin
            rx_data_valid <= 1'b1;
            rx_data       <= rx_payload;
            rx_data_sop   <= sop_pend;
            rx_data_eop   <= (remain == 16'd1);
            sop_pend      <= 1'b0;
            remain        <= remain - 16'd1;
            if (remain == 16'd1)
              state <= ST_DISCARD;
          end
          default: ; // ST_DISCARD: swallow bytes until valid falls
        endcase
      end
    end
  end

endmodule
